mux4_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 32-bit 4:1 datapath mux among four requesters.

---
 rtl/mux4_arb_pkg.sv | 34 +++
 rtl/mux4_sel.sv | 26 ++
 rtl/mux4_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux4_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the four-requester bus arbiter.
// Holds the FSM state type, the requester/select sizes and the round-robin pick function.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Scan last+1, last+2, ... (mod NUM_REQ) and return the first requester found.
  // The caller only uses the result when at least one request bit is set.
  function automatic logic [SEL_W-1:0] rrPick(input logic [NUM_REQ-1:0] req,
                                              input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rrPick = last;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && req[idx]) begin
        rrPick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] selToOneHot(input logic [SEL_W-1:0] sel);
    selToOneHot = NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// Purely combinational WIDTH-wide 4:1 data mux.
// Used by the arbiter to pick the current owner's word before it is registered onto the bus.
module mux4_sel
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 datapath mux and registers the selected word onto a bus.
// Optional feature: define MUX4_ARB_TIMEOUT_EN to revoke a grant held HOLD_MAX cycles while others wait.
module mux4_bus_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [WIDTH-1:0]   i_din0,
  input  logic [WIDTH-1:0]   i_din1,
  input  logic [WIDTH-1:0]   i_din2,
  input  logic [WIDTH-1:0]   i_din3,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0]   o_mux_sel,
  output logic [WIDTH-1:0]   o_bus_out,
  output logic               o_bus_valid,
  output logic               o_timeout
);

  if (HOLD_MAX < 2) begin : gHoldMaxCheck
    $error("mux4_bus_arbiter: HOLD_MAX must be at least 2");
  end

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic [WIDTH-1:0]   r_busOut;
  logic               r_busValid;

  logic [WIDTH-1:0]   w_muxOut;
  logic               w_ownerReq;
  logic [NUM_REQ-1:0] w_othersReq;
  logic [SEL_W-1:0]   w_winner;

  mux4_sel #(
    .WIDTH (WIDTH)
  ) uDinMux (
    .i_sel (r_sel),
    .i_d0  (i_din0),
    .i_d1  (i_din1),
    .i_d2  (i_din2),
    .i_d3  (i_din3),
    .o_y   (w_muxOut)
  );

  // Masking the current owner lets one pick serve idle grants, handoffs and forced revokes.
  assign w_ownerReq  = i_req[r_sel];
  assign w_othersReq = i_req & ~r_gnt;
  assign w_winner    = rrPick(w_othersReq, r_last);

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int HOLD_CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

  logic [HOLD_CNT_W-1:0] r_holdCnt;
  logic                  r_timeout;

  // Counts completed owner cycles; saturates at HOLD_LAST so a lone owner keeps its grant.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_holdCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        r_holdCnt <= '0;
      end else if (!w_ownerReq) begin
        r_holdCnt <= '0;
      end else if (r_holdCnt == HOLD_LAST) begin
        if (|w_othersReq) begin
          r_holdCnt <= '0;
          r_timeout <= 1'b1;
        end
      end else begin
        r_holdCnt <= r_holdCnt + 1'b1;
      end
    end
  end

  logic w_forceRevoke;
  assign w_forceRevoke = (r_holdCnt == HOLD_LAST) && (|w_othersReq);
  assign o_timeout     = r_timeout;
`else
  logic w_forceRevoke;
  assign w_forceRevoke = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  // Arbiter FSM with registered grant, select and bus outputs; reset wins even mid-grant.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_last     <= SEL_W'(NUM_REQ - 1);
      r_busOut   <= '0;
      r_busValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_busValid <= 1'b0;
          if (|i_req) begin
            r_gnt   <= selToOneHot(w_winner);
            r_sel   <= w_winner;
            r_last  <= w_winner;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_busOut   <= w_muxOut;
          r_busValid <= w_ownerReq;
          if (w_ownerReq) begin
            if (w_forceRevoke) begin
              r_gnt  <= selToOneHot(w_winner);
              r_sel  <= w_winner;
              r_last <= w_winner;
            end
          end else if (|w_othersReq) begin
            r_gnt  <= selToOneHot(w_winner);
            r_sel  <= w_winner;
            r_last <= w_winner;
          end else begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_mux_sel   = r_sel;
  assign o_bus_out   = r_busOut;
  assign o_bus_valid = r_busValid;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Self-checking bench for mux4_bus_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model (honours MUX4_ARB_TIMEOUT_EN).
module tb_mux4_bus_arbiter;

  localparam int WIDTH    = 32;
  localparam int HOLD_MAX = 4;

  logic             clk;
  logic             resetN;
  logic [3:0]       req;
  logic [WIDTH-1:0] din [4];
  logic [3:0]       gnt;
  logic [1:0]       muxSel;
  logic [WIDTH-1:0] busOut;
  logic             busValid;
  logic             timeout;

  int checkCount;
  int errorCount;

  // Behavioural model state: owner is -1 when nobody holds the bus.
  int             mOwner;
  int             mLast;
  int             mSel;
  int             mHeld;
  logic [31:0]    mBus;
  logic           mValid;
  logic           mTimeout;

  mux4_bus_arbiter #(
    .WIDTH    (WIDTH),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (resetN),
    .i_req       (req),
    .i_din0      (din[0]),
    .i_din1      (din[1]),
    .i_din2      (din[2]),
    .i_din3      (din[3]),
    .o_gnt       (gnt),
    .o_mux_sel   (muxSel),
    .o_bus_out   (busOut),
    .o_bus_valid (busValid),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickNext(input logic [3:0] r, input int last, input int exclude);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (r[idx] && idx != exclude) return idx;
    end
    return -1;
  endfunction

  task automatic grantTo(input int who);
    mOwner = who;
    mLast  = who;
    mSel   = who;
    mHeld  = 1;
  endtask

  // Predicts what the arbiter shows after the next rising edge given the current inputs.
  task automatic modelStep();
    int nxt;
    if (!resetN) begin
      mOwner = -1; mLast = 3; mSel = 0; mHeld = 0;
      mBus = '0; mValid = 1'b0; mTimeout = 1'b0;
      return;
    end
    mTimeout = 1'b0;
    nxt = pickNext(req, mLast, mOwner);
    if (mOwner < 0) begin
      mValid = 1'b0;
      if (nxt >= 0) grantTo(nxt);
    end else begin
      mBus   = din[mOwner];
      mValid = req[mOwner];
      if (req[mOwner]) begin
`ifdef MUX4_ARB_TIMEOUT_EN
        if (mHeld >= HOLD_MAX && nxt >= 0) begin
          grantTo(nxt);
          mTimeout = 1'b1;
        end else begin
          mHeld++;
        end
`else
        mHeld++;
`endif
      end else if (nxt >= 0) begin
        grantTo(nxt);
      end else begin
        mOwner = -1;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model on the edge and compares every output.
  task automatic applyStimulus(input logic [3:0] reqIn, input logic rstN);
    req    = reqIn;
    resetN = rstN;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("gnt",       32'(gnt),      (mOwner < 0) ? 32'h0 : 32'(4'b0001 << mOwner));
    checkOutput("mux_sel",   32'(muxSel),   32'(mSel));
    checkOutput("bus_out",   busOut,        mBus);
    checkOutput("bus_valid", 32'(busValid), 32'(mValid));
    checkOutput("timeout",   32'(timeout),  32'(mTimeout));
  endtask

  task automatic randomDin();
    for (int i = 0; i < 4; i++) din[i] = $urandom;
  endtask

  initial begin
    logic [3:0] rrReq [5];
    logic [3:0] rrGnt [5];
    logic [3:0] rndReq;
    checkCount = 0;
    errorCount = 0;
    req    = '0;
    resetN = 1'b0;
    randomDin();
    @(negedge clk);

    // Reset held with every requester asking
    repeat (3) applyStimulus(4'hF, 1'b0);
    checkOutput("reset_gnt",   32'(gnt),      32'h0);
    checkOutput("reset_sel",   32'(muxSel),   32'h0);
    checkOutput("reset_valid", 32'(busValid), 32'h0);

    // Single requester with known data
    din[2] = 32'hDEADBEEF;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_bus",   busOut,        32'hDEADBEEF);
    checkOutput("single_valid", 32'(busValid), 32'h1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_release", 32'(gnt), 32'h0);

    // Round-robin order with back-to-back handoffs
    applyStimulus(4'hF, 1'b0);
    rrReq = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7};
    rrGnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 5; i++) begin
      randomDin();
      applyStimulus(rrReq[i], 1'b1);
      checkOutput("rr_gnt", 32'(gnt), 32'(rrGnt[i]));
    end

    // Handoff from owner 1 to waiting requester 3
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("hold_gnt", 32'(gnt), 32'h2);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("handoff_gnt", 32'(gnt),    32'h8);
    checkOutput("handoff_sel", 32'(muxSel), 32'h3);

    // Reset while requester 2 owns the bus
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'hF, 1'b0);
    checkOutput("midreset_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'hF, 1'b1);
    checkOutput("postreset_gnt", 32'(gnt), 32'h1);

    // Long hold by requester 0 with requester 1 waiting
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    repeat (HOLD_MAX - 1) applyStimulus(4'b0011, 1'b1);
    checkOutput("hold_before_limit", 32'(gnt), 32'h1);
    applyStimulus(4'b0011, 1'b1);
`ifdef MUX4_ARB_TIMEOUT_EN
    checkOutput("timeout_gnt",   32'(gnt),     32'h2);
    checkOutput("timeout_pulse", 32'(timeout), 32'h1);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("timeout_clear", 32'(timeout), 32'h0);
`else
    checkOutput("no_timeout_gnt",   32'(gnt),     32'h1);
    checkOutput("no_timeout_pulse", 32'(timeout), 32'h0);
`endif
    applyStimulus(4'h0, 1'b0);
    repeat (3 * HOLD_MAX) applyStimulus(4'b0001, 1'b1);
    checkOutput("lone_owner_kept", 32'(gnt), 32'h1);

    // Randomized traffic with sticky requests and occasional resets
    rndReq = '0;
    for (int c = 0; c < 1500; c++) begin
      randomDin();
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rndReq[b] = ~rndReq[b];
      end
      applyStimulus(rndReq, ($urandom_range(0, 99) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
